// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero.
module mips_register_file #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write_i,
  input  logic [SIZE-1:0]  write_register_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [SIZE-1:0]  read_register_1_i,
  input  logic [SIZE-1:0]  read_register_2_i,
  output logic [WIDTH-1:0] read_data_1_o,
  output logic [WIDTH-1:0] read_data_2_o
);

  localparam int NREG = 1 << SIZE;

  // Entry 0 has no storage; it is synthesised away as a constant zero.
  logic [WIDTH-1:0] regs_r [1:NREG-1];
  logic [NREG-1:1]  wr_en_s;
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  // One-hot write decoder gated by the write enable
  always_comb begin
    wr_en_s = '0;
    for (int i = 1; i < NREG; i++) begin
      if (reg_write_i && (write_register_i == SIZE'(i))) begin
        wr_en_s[i] = 1'b1;
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en_s[i]) begin
          regs_r[i] <= write_data_i;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read port 1 mux; index 0 returns zero
  always_comb begin
    rd1_s = '0;
    if (read_register_1_i != {SIZE{1'b0}}) begin
      rd1_s = regs_r[read_register_1_i];
    end else begin
      rd1_s = '0;
    end
  end

  // Read port 2 mux; index 0 returns zero
  always_comb begin
    rd2_s = '0;
    if (read_register_2_i != {SIZE{1'b0}}) begin
      rd2_s = regs_r[read_register_2_i];
    end else begin
      rd2_s = '0;
    end
  end

  assign read_data_1_o = rd1_s;
  assign read_data_2_o = rd2_s;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file.
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_i;
  logic [4:0]  write_register_i;
  logic [31:0] write_data_i;
  logic [4:0]  read_register_1_i;
  logic [4:0]  read_register_2_i;
  logic [31:0] read_data_1_o;
  logic [31:0] read_data_2_o;

  int vectors = 0;
  int miscompares = 0;

  mips_register_file #(.WIDTH(32), .SIZE(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .reg_write_i       (reg_write_i),
    .write_register_i  (write_register_i),
    .write_data_i      (write_data_i),
    .read_register_1_i (read_register_1_i),
    .read_register_2_i (read_register_2_i),
    .read_data_1_o     (read_data_1_o),
    .read_data_2_o     (read_data_2_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_both(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    read_register_1_i = idx;
    read_register_2_i = idx;
    #1;
    chk({tag, "_p1"}, read_data_1_o, exp);
    chk({tag, "_p2"}, read_data_2_o, exp);
  endtask

  task automatic wr_at_negedge(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write_i      = 1'b1;
    write_register_i = a;
    write_data_i     = d;
  endtask

  initial begin
    // Reset held low with writes requested and the clock running
    reset             = 1'b0;
    reg_write_i       = 1'b1;
    write_register_i  = 5'd2;
    write_data_i      = 32'd55;
    read_register_1_i = 5'd0;
    read_register_2_i = 5'd0;
    #2;
    rd_both("rst_r0", 5'd0, 32'd0);
    rd_both("rst_r2", 5'd2, 32'd0);
    rd_both("rst_r31", 5'd31, 32'd0);
    @(posedge clk); #1;
    rd_both("rst_blocked_r2", 5'd2, 32'd0);
    @(negedge clk);
    reset       = 1'b1;
    reg_write_i = 1'b0;
    @(posedge clk); #1;
    rd_both("post_rst_r2", 5'd2, 32'd0);
    rd_both("post_rst_r31", 5'd31, 32'd0);

    // Basic writes on successive edges
    wr_at_negedge(5'd2, 32'd7);
    wr_at_negedge(5'd4, 32'd20);
    wr_at_negedge(5'd25, 32'd6);
    wr_at_negedge(5'd31, 32'd78);
    @(negedge clk);
    reg_write_i = 1'b0;
    rd_both("wr_r2", 5'd2, 32'd7);
    rd_both("wr_r4", 5'd4, 32'd20);
    rd_both("wr_r25", 5'd25, 32'd6);
    rd_both("wr_r31", 5'd31, 32'd78);

    // Writes to r0 are ignored
    wr_at_negedge(5'd0, 32'd3);
    @(negedge clk);
    reg_write_i = 1'b0;
    rd_both("zero_r0", 5'd0, 32'd0);

    // Write disabled
    @(negedge clk);
    reg_write_i      = 1'b0;
    write_register_i = 5'd4;
    write_data_i     = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd_both("wdis_r4", 5'd4, 32'd20);

    // Independent ports
    read_register_1_i = 5'd2;
    read_register_2_i = 5'd31;
    #1;
    chk("dual_p1", read_data_1_o, 32'd7);
    chk("dual_p2", read_data_2_o, 32'd78);

    // Same-cycle write/read: old value before the edge, new after
    wr_at_negedge(5'd2, 32'h1234_5678);
    read_register_1_i = 5'd2;
    #1;
    chk("same_old", read_data_1_o, 32'd7);
    @(posedge clk); #1;
    chk("same_new", read_data_1_o, 32'h1234_5678);
    reg_write_i = 1'b0;

    // Asynchronous reset between clock edges
    @(negedge clk);
    read_register_1_i = 5'd31;
    read_register_2_i = 5'd25;
    #1;
    chk("pre_arst_p1", read_data_1_o, 32'd78);
    chk("pre_arst_p2", read_data_2_o, 32'd6);
    reset = 1'b0;
    #1;
    chk("arst_p1", read_data_1_o, 32'd0);
    chk("arst_p2", read_data_2_o, 32'd0);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_arst_r31", read_data_1_o, 32'd0);
    chk("post_arst_r25", read_data_2_o, 32'd0);
    wr_at_negedge(5'd31, 32'hA5A5_0001);
    @(negedge clk);
    reg_write_i = 1'b0;
    rd_both("rewrite_r31", 5'd31, 32'hA5A5_0001);
    rd_both("rewrite_r4", 5'd4, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
